// File: rtl/booth_multiplier.sv
// Sequential signed WIDTH x WIDTH multiplier using radix-2 Booth recoding.
// One Booth step per clock; the 2*WIDTH-bit product is presented as HI/LO with a done pulse.
module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic [WIDTH:0]   m_sext;
  logic [WIDTH:0]   sum;
  logic             accept;
  logic             last_step;

  // P carries one extra bit so that subtracting the most-negative M cannot overflow.
  always_comb begin
    m_sext = {m_q[WIDTH-1], m_q};
    sum    = p_q;
    case ({q_q[0], q1_q})
      2'b01:   sum = p_q + m_sext;
      2'b10:   sum = p_q - m_sext;
      default: sum = p_q;
    endcase
    p_d  = {sum[WIDTH], sum[WIDTH:1]};
    q_d  = {sum[0], q_q[WIDTH-1:1]};
    q1_d = q_q[0];
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    accept    = (state_q == IDLE) && start;
    last_step = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
    HI        = hi_q;
    LO        = lo_q;
    done      = done_q;
  end

  // Operands are latched only on an accepted start; a start seen during RUN is ignored.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m_q    <= '0;
      p_q    <= '0;
      q_q    <= '0;
      q1_q   <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_step;
      if (accept) begin
        m_q   <= A;
        q_q   <= B;
        p_q   <= '0;
        q1_q  <= 1'b0;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        p_q   <= p_d;
        q_q   <= q_d;
        q1_q  <= q1_d;
        cnt_q <= cnt_q + CW'(1);
        if (last_step) begin
          hi_q <= p_d[WIDTH-1:0];
          lo_q <= q_d;
        end
      end
    end
  end

endmodule
